// File: rtl/pe_stu_tx.sv
// PE-side upstream stack-bus transmitter: framing check, input FIFO, registered output stage, OOB tagging.
// Optional stall watchdog is built when PE_STU_TX_STALL_TIMEOUT_EN is defined.
module pe_stu_tx #(
  parameter int DATA_W        = 64,
  parameter int TYPE_W        = 2,
  parameter int FIFO_DEPTH    = 8,
  parameter int PE_ID_W       = 6,
  parameter int SEQ_W         = 8,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       src__stutx__valid,
  input  logic [1:0]                 src__stutx__cntl,
  input  logic [TYPE_W-1:0]          src__stutx__type,
  input  logic [DATA_W-1:0]          src__stutx__data,
  output logic                       stutx__src__ready,
  output logic                       pe__stu__valid,
  output logic [1:0]                 pe__stu__cntl,
  output logic [TYPE_W-1:0]          pe__stu__type,
  output logic [DATA_W-1:0]          pe__stu__data,
  output logic [PE_ID_W+SEQ_W-1:0]   pe__stu__oob_data,
  input  logic                       stu__pe__ready,
  input  logic [PE_ID_W-1:0]         sys__stutx__pe_id,
  output logic                       stutx__sys__proto_err,
  output logic                       stutx__sys__stall_err,
  output logic [15:0]                stutx__sys__pkt_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + TYPE_W + DATA_W;

  localparam logic [1:0] CNTL_MOM     = 2'b00;
  localparam logic [1:0] CNTL_SOM     = 2'b01;
  localparam logic [1:0] CNTL_EOM     = 2'b10;
  localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

  typedef enum logic {IN_IDLE, IN_PKT} in_state_t;

  in_state_t               in_state_reg, in_state_next;
  logic                    in_write, in_err, accept;
  logic                    src_ready_reg, proto_err_reg;
  logic [ENTRY_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]        count_reg, count_after_pop, count_next;
  logic                    head_valid_reg;
  logic [ENTRY_W-1:0]      head_data_reg;
  logic                    load, handshake, pkt_end;
  logic                    out_valid_reg;
  logic [1:0]              out_cntl_reg;
  logic [TYPE_W-1:0]       out_type_reg;
  logic [DATA_W-1:0]       out_data_reg;
  logic [PE_ID_W+SEQ_W-1:0] out_oob_reg;
  logic [SEQ_W-1:0]        seq_reg, seq_next;
  logic [15:0]             pkt_count_reg;

  assign accept = src__stutx__valid && src_ready_reg;

  // Framing checker; dropped words still complete the handshake.
  always_comb begin
    in_state_next = in_state_reg;
    in_write      = 1'b0;
    in_err        = 1'b0;
    if (accept) begin
      case (in_state_reg)
        IN_IDLE: begin
          case (src__stutx__cntl)
            CNTL_SOM: begin
              in_write      = 1'b1;
              in_state_next = IN_PKT;
            end
            CNTL_SOM_EOM: in_write = 1'b1;
            default:      in_err   = 1'b1;
          endcase
        end
        IN_PKT: begin
          case (src__stutx__cntl)
            CNTL_MOM: in_write = 1'b1;
            CNTL_EOM: begin
              in_write      = 1'b1;
              in_state_next = IN_IDLE;
            end
            default:  in_err = 1'b1;
          endcase
        end
        default: in_state_next = IN_IDLE;
      endcase
    end
  end

  // head_valid_reg only covers entries written before the current edge, so the
  // registered RAM read never returns a word still being written.
  assign handshake       = out_valid_reg && stu__pe__ready;
  assign load            = (!out_valid_reg || stu__pe__ready) && head_valid_reg;
  assign pkt_end         = handshake && out_cntl_reg[1];
  assign seq_next        = seq_reg + SEQ_W'(pkt_end);
  assign rd_ptr_next     = rd_ptr_reg + PTR_W'(load);
  assign count_after_pop = count_reg - CNT_W'(load);
  assign count_next      = count_after_pop + CNT_W'(in_write);

  always_ff @(posedge clk) begin
    if (in_write) mem[wr_ptr_reg] <= {src__stutx__cntl, src__stutx__type, src__stutx__data};
    head_data_reg <= mem[rd_ptr_next];
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      in_state_reg   <= IN_IDLE;
      src_ready_reg  <= 1'b1;
      proto_err_reg  <= 1'b0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_cntl_reg   <= '0;
      out_type_reg   <= '0;
      out_data_reg   <= '0;
      out_oob_reg    <= '0;
      seq_reg        <= '0;
      pkt_count_reg  <= '0;
    end else begin
      in_state_reg   <= in_state_next;
      src_ready_reg  <= (count_next != CNT_W'(FIFO_DEPTH));
      if (in_err) proto_err_reg <= 1'b1;
      if (in_write) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      head_valid_reg <= (count_after_pop != '0);
      seq_reg        <= seq_next;
      pkt_count_reg  <= pkt_count_reg + 16'(pkt_end);
      if (load) begin
        out_valid_reg <= 1'b1;
        out_cntl_reg  <= head_data_reg[ENTRY_W-1 -: 2];
        out_type_reg  <= head_data_reg[DATA_W +: TYPE_W];
        out_data_reg  <= head_data_reg[DATA_W-1:0];
        out_oob_reg   <= {sys__stutx__pe_id, seq_next};
      end else if (stu__pe__ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef PE_STU_TX_STALL_TIMEOUT_EN
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);
  logic [STALL_W-1:0] stall_cnt_reg;
  logic               stall_err_reg;

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      stall_cnt_reg <= '0;
      stall_err_reg <= 1'b0;
    end else if (out_valid_reg && !stu__pe__ready) begin
      if (stall_cnt_reg != STALL_W'(STALL_TIMEOUT)) stall_cnt_reg <= stall_cnt_reg + STALL_W'(1);
      if (stall_cnt_reg == STALL_W'(STALL_TIMEOUT - 1)) stall_err_reg <= 1'b1;
    end else begin
      stall_cnt_reg <= '0;
    end
  end

  assign stutx__sys__stall_err = stall_err_reg;
`else
  assign stutx__sys__stall_err = 1'b0;
`endif

  assign stutx__src__ready     = src_ready_reg;
  assign pe__stu__valid        = out_valid_reg;
  assign pe__stu__cntl         = out_cntl_reg;
  assign pe__stu__type         = out_type_reg;
  assign pe__stu__data         = out_data_reg;
  assign pe__stu__oob_data     = out_oob_reg;
  assign stutx__sys__proto_err = proto_err_reg;
  assign stutx__sys__pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_pe_stu_tx.sv
// Directed bench for pe_stu_tx: framing table plus latency, backpressure, seq wrap and mid-packet reset sequences.
module tb_pe_stu_tx;
  localparam logic [5:0] PE = 6'd3;

`ifdef PE_STU_TX_STALL_TIMEOUT_EN
  localparam logic EXP_STALL = 1'b1;
`else
  localparam logic EXP_STALL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic [1:0]  src_cntl = 2'b00;
  logic [1:0]  src_type = 2'b01;
  logic [63:0] src_data = '0;
  logic        src_ready;
  logic        pe_valid;
  logic [1:0]  pe_cntl;
  logic [1:0]  pe_type;
  logic [63:0] pe_data;
  logic [13:0] pe_oob;
  logic        stu_ready = 1'b0;
  logic [5:0]  pe_id = PE;
  logic        proto_err, stall_err;
  logic [15:0] pkt_count;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pe_stu_tx #(
    .DATA_W(64), .TYPE_W(2), .FIFO_DEPTH(8), .PE_ID_W(6), .SEQ_W(8), .STALL_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset_poweron(rst),
    .src__stutx__valid(src_valid),
    .src__stutx__cntl(src_cntl),
    .src__stutx__type(src_type),
    .src__stutx__data(src_data),
    .stutx__src__ready(src_ready),
    .pe__stu__valid(pe_valid),
    .pe__stu__cntl(pe_cntl),
    .pe__stu__type(pe_type),
    .pe__stu__data(pe_data),
    .pe__stu__oob_data(pe_oob),
    .stu__pe__ready(stu_ready),
    .sys__stutx__pe_id(pe_id),
    .stutx__sys__proto_err(proto_err),
    .stutx__sys__stall_err(stall_err),
    .stutx__sys__pkt_count(pkt_count)
  );

  typedef struct {
    logic [1:0]  cntl;
    logic [63:0] data;
    logic [13:0] oob;
    int          cyc;
  } beat_t;

  beat_t q[$];
  int    cyc = 0;

  // Upstream monitor: a beat valid with ready high at the negedge completes at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst && pe_valid && stu_ready) q.push_back('{pe_cntl, pe_data, pe_oob, cyc});
  end

  typedef struct {
    logic [1:0]  cntl;
    logic [63:0] data;
    logic        fwd;
    logic [7:0]  seq;
    logic        perr;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push(input logic [1:0] c, input logic [63:0] d);
    int n;
    n = 0;
    @(negedge clk);
    src_valid = 1'b1;
    src_cntl  = c;
    src_data  = d;
    while (!src_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      tests++;
      failed++;
      $display("FAIL push_timeout: got ready=0 for %0d cycles expected ready=1", n);
    end
    @(posedge clk); #1;
    src_valid = 1'b0;
  endtask

  function automatic logic [1:0] bp_cntl(input int i);
    if (i == 0) return 2'b01;
    if (i == 9) return 2'b10;
    return 2'b00;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int idx;

    vecs[0] = '{2'b11, 64'h00A5, 1'b1, 8'd1, 1'b0};
    vecs[1] = '{2'b01, 64'h0001, 1'b1, 8'd2, 1'b0};
    vecs[2] = '{2'b00, 64'h0002, 1'b1, 8'd2, 1'b0};
    vecs[3] = '{2'b10, 64'h0003, 1'b1, 8'd2, 1'b0};
    vecs[4] = '{2'b10, 64'h0044, 1'b0, 8'd0, 1'b1};
    vecs[5] = '{2'b01, 64'h0010, 1'b1, 8'd3, 1'b1};
    vecs[6] = '{2'b01, 64'h0011, 1'b0, 8'd0, 1'b1};
    vecs[7] = '{2'b10, 64'h0012, 1'b1, 8'd3, 1'b1};
    vecs[8] = '{2'b11, 64'h0020, 1'b1, 8'd4, 1'b1};

    // Reset state
    do_reset();
    chk("rst_valid", 64'(pe_valid), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'd1);
    chk("rst_oob", 64'(pe_oob), 64'd0);
    chk("rst_data", pe_data, 64'd0);
    chk("rst_perr", 64'(proto_err), 64'd0);
    chk("rst_serr", 64'(stall_err), 64'd0);
    chk("rst_pkt", 64'(pkt_count), 64'd0);
    $display("[TB] reset checked");

    // Single-beat latency
    stu_ready = 1'b1;
    push(2'b11, 64'hA5);
    chk("lat_k", 64'(pe_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_k1", 64'(pe_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat_k2_valid", 64'(pe_valid), 64'd1);
    chk("lat_k2_cntl", 64'(pe_cntl), 64'd3);
    chk("lat_k2_type", 64'(pe_type), 64'd1);
    chk("lat_k2_data", pe_data, 64'hA5);
    chk("lat_k2_oob", 64'(pe_oob), 64'({PE, 8'd0}));
    @(posedge clk); #1;
    chk("lat_pkt", 64'(pkt_count), 64'd1);
    chk("lat_drain", 64'(pe_valid), 64'd0);
    $display("[TB] single beat: data=%0h oob=%0h", 64'hA5, {PE, 8'd0});
    q.delete();

    // Framing table
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].cntl, vecs[i].data);
      chk($sformatf("tbl%0d_perr", i), 64'(proto_err), 64'(vecs[i].perr));
      $display("[TB] vec %0d cntl=%0d data=%0h", i, vecs[i].cntl, vecs[i].data);
    end
    repeat (8) @(posedge clk);
    #1;
    chk("tbl_beats", 64'(q.size()), 64'd7);
    k = 0;
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].fwd) begin
        if (k < q.size()) begin
          chk($sformatf("tbl%0d_data", i), q[k].data, vecs[i].data);
          chk($sformatf("tbl%0d_cntl", i), 64'(q[k].cntl), 64'(vecs[i].cntl));
          chk($sformatf("tbl%0d_oob", i), 64'(q[k].oob), 64'({PE, vecs[i].seq}));
        end
        k++;
      end
    end
    if (q.size() >= 4) begin
      chk("b2b_12", 64'(q[2].cyc - q[1].cyc), 64'd1);
      chk("b2b_23", 64'(q[3].cyc - q[2].cyc), 64'd1);
    end
    chk("tbl_pkt", 64'(pkt_count), 64'd5);

    // Backpressure and fill
    do_reset();
    stu_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      src_valid = 1'b1;
      src_cntl  = bp_cntl(idx);
      src_data  = 64'h100 + 64'(idx);
      if (src_ready) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd9);
    chk("bp_ready", 64'(src_ready), 64'd0);
    chk("bp_hold_valid", 64'(pe_valid), 64'd1);
    chk("bp_hold_data", pe_data, 64'h100);
    chk("bp_hold_cntl", 64'(pe_cntl), 64'd1);
    chk("bp_stall_err", 64'(stall_err), 64'(EXP_STALL));
    $display("[TB] fill: accepted=%0d ready=%0d", idx, src_ready);
    q.delete();
    @(posedge clk); #1;
    stu_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (idx < 10) begin
        src_valid = 1'b1;
        src_cntl  = bp_cntl(idx);
        src_data  = 64'h100 + 64'(idx);
        if (src_ready) idx++;
      end else begin
        src_valid = 1'b0;
      end
    end
    chk("bp_all_accepted", 64'(idx), 64'd10);
    chk("bp_drained", 64'(q.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < q.size()) begin
        chk($sformatf("bp%0d_data", i), q[i].data, 64'h100 + 64'(i));
        chk($sformatf("bp%0d_cntl", i), 64'(q[i].cntl), 64'(bp_cntl(i)));
      end
    end
    chk("bp_stall_sticky", 64'(stall_err), 64'(EXP_STALL));
    chk("bp_pkt", 64'(pkt_count), 64'd1);

    // Sequence wrap
    do_reset();
    stu_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 256; i++) push(2'b11, 64'(i));
    repeat (5) @(posedge clk);
    #1;
    chk("wrap_beats", 64'(q.size()), 64'd256);
    if (q.size() == 256) chk("wrap_seq255", 64'(q[255].oob), 64'({PE, 8'd255}));
    chk("wrap_pkt", 64'(pkt_count), 64'd256);
    push(2'b11, 64'h257);
    repeat (5) @(posedge clk);
    #1;
    if (q.size() == 257) chk("wrap_seq0", 64'(q[256].oob), 64'({PE, 8'd0}));
    else chk("wrap_257_beats", 64'(q.size()), 64'd257);
    $display("[TB] wrap: pkt_count=%0d", pkt_count);

    // Mid-packet reset
    stu_ready = 1'b0;
    push(2'b01, 64'h55);
    push(2'b00, 64'h56);
    do_reset();
    chk("mrst_valid", 64'(pe_valid), 64'd0);
    chk("mrst_ready", 64'(src_ready), 64'd1);
    chk("mrst_pkt", 64'(pkt_count), 64'd0);
    stu_ready = 1'b1;
    q.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_empty", 64'(q.size()), 64'd0);
    push(2'b11, 64'h77);
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_beats", 64'(q.size()), 64'd1);
    if (q.size() >= 1) begin
      chk("mrst_data", q[0].data, 64'h77);
      chk("mrst_oob", 64'(q[0].oob), 64'({PE, 8'd0}));
    end
    chk("mrst_perr", 64'(proto_err), 64'd0);
    $display("[TB] mid-packet reset: beats=%0d", q.size());

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
